// File: rtl/slon5_pkg.sv
// Shared types for the slon5 round datapath and its job scheduler.
// Stage and requester-id widths track the default core configuration.
package slon5_pkg;

    localparam int STAGE_NUM     = 16;
    localparam int STAGE_W       = $clog2(STAGE_NUM);
    localparam int SCHED_REQ_NUM = 4;
    localparam int SCHED_ID_W    = $clog2(SCHED_REQ_NUM);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } SchedState_t;

    typedef logic [STAGE_W-1:0]    Stage_t;
    typedef logic [SCHED_ID_W-1:0] ReqId_t;

endpackage

// File: rtl/slon5_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
// Grant is one-hot; win is the encoded index of the granted requester.
module slon5_rr_arb #(
    parameter int  REQ_NUM = 4,
    localparam int ID_W    = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [REQ_NUM-1:0] gnt,
    output logic [ID_W-1:0]    win
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt = '0;
        win = '0;
        idx = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            idx = ID_W'((32'(ptr) + 32'(i)) % REQ_NUM);
            if (en && req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

endmodule

// File: rtl/slon5_sched.sv
// Round-robin job scheduler sharing one iterative slon5 round core:
// grant, load, step STAGE_NUM rounds, then return the tagged result.
module slon5_sched #(
    parameter int  REQ_NUM   = 4,
    parameter int  STAGE_NUM = slon5_pkg::STAGE_NUM,
    parameter int  DATA_W    = 32,
    localparam int ID_W      = $clog2(REQ_NUM),
    localparam int STAGE_W   = $clog2(STAGE_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_NUM-1:0]             req_valid,
    input  logic [REQ_NUM-1:0][DATA_W-1:0] req_data,
    output logic [REQ_NUM-1:0]             req_ready,
    output logic                           core_load,
    output logic [DATA_W-1:0]              core_din,
    output logic                           core_en,
    output logic [STAGE_W-1:0]             core_stage,
    output logic                           core_last,
    input  logic [DATA_W-1:0]              core_dout,
    input  logic                           hold,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic [DATA_W-1:0]              resp_data,
    output logic                           busy
);

    import slon5_pkg::*;

    SchedState_t        state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    job_id_q, job_id_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               first_q, first_d;
    logic [REQ_NUM-1:0] gnt;
    logic [ID_W-1:0]    win;

    slon5_rr_arb #(
        .REQ_NUM (REQ_NUM)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (state_q == IDLE),
        .gnt (gnt),
        .win (win)
    );

    assign req_ready  = gnt;
    assign busy       = (state_q != IDLE);
    assign core_din   = din_q;
    assign core_stage = stage_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        job_id_d   = job_id_q;
        stage_d    = stage_q;
        din_d      = din_q;
        res_d      = res_q;
        first_d    = 1'b0;
        core_load  = 1'b0;
        core_en    = 1'b0;
        core_last  = 1'b0;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    din_d    = req_data[win];
                    job_id_d = win;
                    rr_ptr_d = (win == ID_W'(REQ_NUM - 1)) ? '0 : win + 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                core_load = 1'b1;
                stage_d   = '0;
                state_d   = RUN;
            end
            RUN: begin
                core_en   = !hold;
                core_last = (stage_q == STAGE_W'(STAGE_NUM - 1)) && !hold;
                if (!hold) begin
                    stage_d = stage_q + 1'b1;
                end
                if (core_last) begin
                    stage_d = '0;
                    first_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Core output is only guaranteed on the entry cycle; keep a copy.
                resp_valid = 1'b1;
                resp_id    = job_id_q;
                resp_data  = first_q ? core_dout : res_q;
                res_d      = resp_data;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            job_id_q <= '0;
            stage_q  <= '0;
            din_q    <= '0;
            res_q    <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            job_id_q <= job_id_d;
            stage_q  <= stage_d;
            din_q    <= din_d;
            res_q    <= res_d;
            first_q  <= first_d;
        end
    end

endmodule

// File: tb/tb_slon5_sched.sv
// Randomised self-checking bench for slon5_sched with a behavioural core
// and a queue-based round-robin / result reference model.
module tb_slon5_sched;

    localparam int RN = 4;
    localparam int SN = 16;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int SW = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [RN-1:0]          req_valid = '0;
    logic [RN-1:0][DW-1:0]  req_data = '0;
    logic [RN-1:0]          req_ready;
    logic                   core_load;
    logic [DW-1:0]          core_din;
    logic                   core_en;
    logic [SW-1:0]          core_stage;
    logic                   core_last;
    logic [DW-1:0]          core_dout;
    logic                   hold = 1'b0;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [IW-1:0]          resp_id;
    logic [DW-1:0]          resp_data;
    logic                   busy;

    always #5 clk = ~clk;

    slon5_sched #(
        .REQ_NUM   (RN),
        .STAGE_NUM (SN),
        .DATA_W    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .core_load  (core_load),
        .core_din   (core_din),
        .core_en    (core_en),
        .core_stage (core_stage),
        .core_last  (core_last),
        .core_dout  (core_dout),
        .hold       (hold),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // Behavioural core: result = loaded operand ^ sum of stages it was stepped through.
    logic [DW-1:0] cm_din = '0;
    logic [DW-1:0] cm_acc = '0;
    always @(posedge clk) begin
        if (core_load) begin
            cm_din <= core_din;
            cm_acc <= '0;
        end else if (core_en) begin
            cm_acc <= cm_acc + DW'(core_stage);
        end
    end
    assign core_dout = cm_din ^ cm_acc;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int m_ptr  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [RN-1:0] vec;
        int            id;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           gq[$];
    ev_t           rq[$];
    ev_t           ge;
    ev_t           re;
    logic [RN-1:0] gnt_seen = '0;

    function automatic int oh2id(logic [RN-1:0] v);
        for (int i = 0; i < RN; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int m_pick(logic [RN-1:0] v, int ptr);
        for (int k = 0; k < RN; k++) if (v[(ptr + k) % RN]) return (ptr + k) % RN;
        return -1;
    endfunction

    function automatic logic [DW-1:0] m_result(logic [DW-1:0] d);
        int s = 0;
        for (int st = 0; st < SN; st++) s += st;
        return d ^ DW'(s);
    endfunction

    // Event recorder: grants and accepted responses, with cycle stamps.
    always @(negedge clk) begin
        gnt_seen = req_valid & req_ready;
        if (!rst && |gnt_seen) begin
            ge.cyc  = cyc;
            ge.vec  = req_valid;
            ge.id   = oh2id(gnt_seen);
            ge.data = req_data[ge.id];
            gq.push_back(ge);
        end
        if (!rst && resp_valid && resp_ready) begin
            re.cyc  = cyc;
            re.vec  = '0;
            re.id   = int'(resp_id);
            re.data = resp_data;
            rq.push_back(re);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~gnt_seen;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        hold       = 1'b0;
        resp_ready = 1'b0;
        repeat (2) next_cycle();
        rst   = 1'b0;
        m_ptr = 0;
        gq.delete();
        rq.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && rq.size() < n; i++) begin
            next_cycle();
            @(negedge clk);
        end
        n_chk++;
        if (rq.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout responses got %0d want %0d", tag, rq.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_chk++;
        if ({busy, req_ready, core_load, core_en, core_last, resp_valid, core_stage, resp_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 0",
                     {busy, req_ready, core_load, core_en, core_last, resp_valid, core_stage, resp_id});
        end
        n_chk++;
        if ({core_din, resp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", {core_din, resp_data});
        end
    endtask

    task automatic test_single();
        logic [3:0] ctl, exp_ctl;
        next_cycle();
        req_data[0] = 32'hA5A5_0001;
        req_valid   = 4'b0001;
        resp_ready  = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant got %b want 0001", req_ready);
        end
        for (int k = 1; k <= 19; k++) begin
            next_cycle();
            @(negedge clk);
            ctl     = {core_load, core_en, core_last, resp_valid};
            exp_ctl = {k == 1, k >= 2 && k <= 17, k == 17, k == 18};
            n_chk++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL single_ctl k=%0d got %b want %b", k, ctl, exp_ctl);
            end
            if (k >= 2 && k <= 17) begin
                n_chk++;
                if (core_stage !== SW'(k - 2)) begin
                    n_fail++;
                    $display("FAIL single_stage k=%0d got %0d want %0d", k, core_stage, k - 2);
                end
            end
            if (k == 1) begin
                n_chk++;
                if (core_din !== 32'hA5A5_0001) begin
                    n_fail++;
                    $display("FAIL single_din got %h want a5a50001", core_din);
                end
            end
            if (k == 18) begin
                n_chk++;
                if (resp_id !== 2'd0 || resp_data !== m_result(32'hA5A5_0001)) begin
                    n_fail++;
                    $display("FAIL single_resp got id %0d data %h want id 0 data %h",
                             resp_id, resp_data, m_result(32'hA5A5_0001));
                end
            end
        end
        m_ptr = 1;
    endtask

    task automatic test_all_four();
        int exp;
        do_reset();
        for (int i = 0; i < RN; i++) req_data[i] = $urandom;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        run_until(4, 120, "all4");
        for (int i = 0; i < 4 && i < gq.size() && i < rq.size(); i++) begin
            exp = m_pick(gq[i].vec, m_ptr);
            n_chk++;
            if (gq[i].id !== exp || rq[i].id !== exp) begin
                n_fail++;
                $display("FAIL all4_order i=%0d got grant %0d resp %0d want %0d",
                         i, gq[i].id, rq[i].id, exp);
            end
            n_chk++;
            if (rq[i].data !== m_result(gq[i].data)) begin
                n_fail++;
                $display("FAIL all4_data i=%0d got %h want %h", i, rq[i].data, m_result(gq[i].data));
            end
            if (i > 0) begin
                n_chk++;
                if (gq[i].cyc - gq[i-1].cyc != SN + 3) begin
                    n_fail++;
                    $display("FAIL all4_spacing i=%0d got %0d want %0d",
                             i, gq[i].cyc - gq[i-1].cyc, SN + 3);
                end
            end
            m_ptr = (exp + 1) % RN;
        end
    endtask

    task automatic test_fairness();
        int exp;
        gq.delete();
        rq.delete();
        next_cycle();
        req_data[2] = $urandom;
        req_valid   = 4'b0100;
        run_until(1, 40, "fair_a");
        next_cycle();
        req_data[0] = $urandom;
        req_data[3] = $urandom;
        req_valid   = 4'b1001;
        run_until(3, 80, "fair_b");
        for (int i = 0; i < 3 && i < gq.size() && i < rq.size(); i++) begin
            exp = m_pick(gq[i].vec, m_ptr);
            n_chk++;
            if (gq[i].id !== exp || rq[i].id !== exp) begin
                n_fail++;
                $display("FAIL fair_order i=%0d got grant %0d resp %0d want %0d",
                         i, gq[i].id, rq[i].id, exp);
            end
            m_ptr = (exp + 1) % RN;
        end
    endtask

    task automatic test_hold();
        int            first = -1;
        logic [DW-1:0] d;
        rq.delete();
        next_cycle();
        d           = $urandom;
        req_data[1] = d;
        req_valid   = 4'b0010;
        resp_ready  = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_grant got %b want 0010", req_ready);
        end
        for (int k = 1; k <= 25; k++) begin
            next_cycle();
            hold = (k == 1) || (k >= 9 && k <= 13);
            @(negedge clk);
            if (k == 1) begin
                n_chk++;
                if (core_load !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold_load got %b want 1", core_load);
                end
            end
            if (k >= 9 && k <= 13) begin
                n_chk++;
                if (core_en !== 1'b0 || core_stage !== SW'(7) || core_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_freeze k=%0d got en %b stage %0d want en 0 stage 7",
                             k, core_en, core_stage);
                end
            end
            if (resp_valid && first < 0) first = k;
        end
        hold = 1'b0;
        n_chk++;
        if (first != 23) begin
            n_fail++;
            $display("FAIL hold_latency got %0d want 23", first);
        end
        n_chk++;
        if (rq.size() != 1 || rq[0].data !== m_result(d) || rq[0].id != 1) begin
            n_fail++;
            $display("FAIL hold_resp got n %0d want 1 data %h", rq.size(), m_result(d));
        end
        m_ptr = 2;
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
        logic [DW-1:0] d;
        bit            seen = 0;
        rq.delete();
        next_cycle();
        d           = $urandom;
        req_data[0] = d;
        req_valid   = 4'b0001;
        resp_ready  = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            next_cycle();
            @(negedge clk);
            seen = resp_valid;
        end
        rid   = resp_id;
        rdata = resp_data;
        n_chk++;
        if (!seen || rid !== 2'd0 || rdata !== m_result(d)) begin
            n_fail++;
            $display("FAIL bp_first got valid %b id %0d data %h want 1 0 %h",
                     seen, rid, rdata, m_result(d));
        end
        for (int j = 0; j < 10; j++) begin
            next_cycle();
            if (j == 0) begin
                req_data[3] = $urandom;
                req_valid   = 4'b1000;
            end
            @(negedge clk);
            n_chk++;
            if (resp_valid !== 1'b1 || resp_id !== rid || resp_data !== rdata ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stable j=%0d got v %b id %0d data %h rdy %b busy %b",
                         j, resp_valid, resp_id, resp_data, req_ready, busy);
            end
        end
        next_cycle();
        resp_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_release got busy %b rdy %b want 0 1000", busy, req_ready);
        end
        run_until(2, 40, "bp_next");
        m_ptr = 0;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        gq.delete();
        rq.delete();
        next_cycle();
        req_data[2] = $urandom;
        req_valid   = 4'b0100;
        resp_ready  = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            next_cycle();
            @(negedge clk);
            found = core_en && core_stage == SW'(9);
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_reach got stage %0d want 9", core_stage);
        end
        next_cycle();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = 0;
        gq.delete();
        rq.delete();
        @(negedge clk);
        n_chk++;
        if ({busy, req_ready, core_load, core_en, core_last, resp_valid, core_stage, resp_id} !== '0 ||
            resp_data !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outs got %b data %h want 0",
                     {busy, req_ready, core_load, core_en, core_last, resp_valid, core_stage, resp_id},
                     resp_data);
        end
        next_cycle();
        req_data[1] = $urandom;
        req_data[3] = $urandom;
        req_valid   = 4'b1010;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_ptr got %b want 0010", req_ready);
        end
        run_until(2, 80, "rstmid");
        n_chk++;
        if (rq.size() != 2 || rq[0].id != 1 || rq[1].id != 3 ||
            rq[0].data !== m_result(gq[0].data)) begin
            n_fail++;
            $display("FAIL rstmid_resp got n %0d ids %0d,%0d want 2 ids 1,3",
                     rq.size(), rq.size() > 0 ? rq[0].id : -1, rq.size() > 1 ? rq[1].id : -1);
        end
    endtask

    task automatic test_random();
        int exp;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            next_cycle();
            for (int i = 0; i < RN; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_data[i]  = $urandom;
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(2) != 0);
            hold       = ($urandom_range(3) == 0);
            @(negedge clk);
            n_chk++;
            if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) begin
                n_fail++;
                $display("FAIL rand_ready c=%0d got %b valid %b", c, req_ready, req_valid);
            end
        end
        next_cycle();
        req_valid  = '0;
        hold       = 1'b0;
        resp_ready = 1'b1;
        repeat (45) next_cycle();
        n_chk++;
        if (rq.size() != gq.size() || gq.size() < 10) begin
            n_fail++;
            $display("FAIL rand_count got resp %0d grants %0d", rq.size(), gq.size());
        end
        for (int i = 0; i < gq.size() && i < rq.size(); i++) begin
            exp = m_pick(gq[i].vec, m_ptr);
            n_chk++;
            if (gq[i].id != exp || rq[i].id != exp || rq[i].data !== m_result(gq[i].data) ||
                rq[i].cyc - gq[i].cyc < SN + 2) begin
                n_fail++;
                $display("FAIL rand_job i=%0d got id %0d/%0d data %h want id %0d data %h",
                         i, gq[i].id, rq[i].id, rq[i].data, exp, m_result(gq[i].data));
            end
            if (i > 0) begin
                n_chk++;
                if (gq[i].cyc - gq[i-1].cyc < SN + 3) begin
                    n_fail++;
                    $display("FAIL rand_spacing i=%0d got %0d", i, gq[i].cyc - gq[i-1].cyc);
                end
            end
            m_ptr = (exp + 1) % RN;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_hold();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
